if_prefetch: RTL and testbench

Parametrised instruction-fetch unit: the next-generation replacement for the PC-plus-ROM fetch path. It owns the fetch PC and issues pipelined requests on a ready/valid instruction bus with variable latency. Returned words are buffered in a prefetch FIFO and handed to decode through a valid/ready handshake. It accepts a redirect (branch/jump/trap) that flushes buffered and in-flight instructions. It sits between the instruction memory port and the ID stage.

---
 rtl/if_prefetch.sv | 111 +++++++++++
 tb/tb_if_prefetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch unit: owns the fetch PC, issues credit-limited requests on a
// variable-latency bus, buffers returned words in a prefetch FIFO for decode.
module if_prefetch #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                PC_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [INST_W-1:0] bus_rdata_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t        DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    cnt_t              outst;
    cnt_t              drop;
    cnt_t              count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW-1:0]     tag_rd, tag_wr;
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
    logic [INST_W-1:0] inst_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_mem  [FIFO_DEPTH];

    logic [CW:0] used;
    logic        issue;
    logic        rsp;
    logic        push;
    logic        pop;

    // Buffered plus in-flight never exceeds the FIFO, so responses need no backpressure.
    assign used      = {1'b0, count} + {1'b0, outst};
    assign bus_req_o = !rst && !redirect_i && (used < DEPTH_W)
                       && (drop == '0 || outst < DEPTH_C);
    assign bus_addr_o = fetch_pc;

    assign issue = bus_req_o && bus_gnt_i;
    assign rsp   = bus_rvalid_i && (outst != '0);
    assign push  = rsp && (drop == '0) && !redirect_i;
    assign pop   = inst_valid_o && inst_ready_i && !redirect_i;

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : '0;
    assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            // NOTE: non-blocking so every update below sees the pre-edge state.
            outst <= outst + cnt_t'(issue) - cnt_t'(rsp);
            if (redirect_i) begin
                // Every response still in flight after this edge is stale; drop is a subset of outst.
                drop     <= outst - cnt_t'(rsp);
                fetch_pc <= redirect_pc_i;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                tag_rd   <= '0;
                tag_wr   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                    tag_wr   <= tag_wr + 1'b1;
                end
                if (rsp && drop != '0) drop <= drop - 1'b1;
                if (push) begin
                    tag_rd <= tag_rd + 1'b1;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; outputs are gated by count so stale words never escape.
    always_ff @(posedge clk) begin
        if (issue) tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]   <= tag_mem[tag_rd];
            inst_mem[wr_ptr] <= bus_rdata_i;
        end
    end

    rvalid_without_outst: assert property (@(posedge clk) disable iff (rst)
        bus_rvalid_i |-> (outst != '0));

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a queue-based bus responder plus per-scenario
// tasks with hand-computed expectations.
module tb_if_prefetch;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        bus_req, bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_addr, bus_rdata = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;

    int          total = 0;
    int          bad = 0;
    int          issue_cnt = 0;
    logic [31:0] last_issue = '0;
    logic        rsp_en = 1'b0;
    logic [31:0] pend[$];

    if_prefetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_gnt_i(bus_gnt),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .inst_o(inst), .inst_pc_o(inst_pc)
    );

    always #5 clk = ~clk;

    // Record every issue at the edge that accepts it.
    initial forever begin
        @(posedge clk);
        if (!rst && bus_req && bus_gnt) begin
            pend.push_back(bus_addr);
            issue_cnt++;
            last_issue = bus_addr;
        end
    end

    // In-order memory: word at address a is a ^ KEY, returned one per cycle when enabled.
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst && rsp_en && pend.size() > 0) begin
            bus_rdata  = pend.pop_front() ^ KEY;
            bus_rvalid = 1'b1;
        end else begin
            bus_rvalid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; rsp_en = 1'b0; bus_gnt = 1'b0; inst_ready = 1'b0;
        tick();
        tick();
        pend.delete();
        issue_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        bus_gnt = 1'b1;
        @(negedge clk);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", inst); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", bus_req); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 0", bus_addr); end
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        bus_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1; rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== 2) begin bad++; $display("FAIL stream_latency: got %0d cycles want 2", n); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k))
                begin bad++; $display("FAIL stream_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", k, inst_valid, inst_pc, 32'(4 * k)); end
            total++;
            if (inst !== (32'(4 * k) ^ KEY))
                begin bad++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst, 32'(4 * k) ^ KEY); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b0; rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        total++; if (issue_cnt !== 4) begin bad++; $display("FAIL bp_issues: got %0d want 4", issue_cnt); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL bp_req_full: got %b want 0", bus_req); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h10) begin bad++; $display("FAIL bp_reissue: got req=%b addr=%h want req=1 addr=10", bus_req, bus_addr); end
        repeat (5) tick();
        @(negedge clk);
        total++; if (issue_cnt !== 5) begin bad++; $display("FAIL bp_one_more: got %0d want 5", issue_cnt); end
        total++; if (bus_req !== 1'b0 || inst_pc !== 32'h4) begin bad++; $display("FAIL bp_after_pop: got req=%b pc=%h want req=0 pc=4", bus_req, inst_pc); end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        bus_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1; rst = 1'b0;
        tick();
        tick();
        bus_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (bus_req !== 1'b1 || bus_addr !== 32'h8) begin bad++; $display("FAIL stall_hold[%0d]: got req=%b addr=%h want req=1 addr=8", c, bus_req, bus_addr); end
            tick();
        end
        total++; if (issue_cnt !== 2) begin bad++; $display("FAIL stall_no_issue: got %0d want 2", issue_cnt); end
        bus_gnt = 1'b1;
        tick();
        total++; if (issue_cnt !== 3 || last_issue !== 32'h8) begin bad++; $display("FAIL stall_resume: got n=%0d addr=%h want n=3 addr=8", issue_cnt, last_issue); end
        @(negedge clk);
        total++; if (bus_addr !== 32'hC) begin bad++; $display("FAIL stall_next: got %h want c", bus_addr); end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        bus_gnt = 1'b1; rsp_en = 1'b0; inst_ready = 1'b0; rst = 1'b0;
        repeat (4) tick();
        rsp_en = 1'b1;
        tick();
        tick();
        rsp_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL redir_req_forced: got %b want 0", bus_req); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL redir_preflush_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
        tick();
        redirect = 1'b0; inst_ready = 1'b1; rsp_en = 1'b1;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed: got %b want 0", inst_valid); end
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin bad++; $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=100", bus_req, bus_addr); end
        n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== 3) begin bad++; $display("FAIL redir_latency: got %0d cycles want 3", n); end
        total++; if (inst_pc !== 32'h100 || inst !== (32'h100 ^ KEY)) begin bad++; $display("FAIL redir_first: got pc=%h inst=%h want pc=100 inst=%h", inst_pc, inst, 32'h100 ^ KEY); end
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin bad++; $display("FAIL redir_second: got v=%b pc=%h want v=1 pc=104", inst_valid, inst_pc); end
    endtask

    task automatic test_redirect_rvalid_pop();
        int n;
        do_reset();
        bus_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1; rst = 1'b0;
        repeat (4) tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || bus_req !== 1'b0) begin bad++; $display("FAIL same_cycle_pre: got v=%b pc=%h req=%b want v=1 pc=8 req=0", inst_valid, inst_pc, bus_req); end
        tick();
        redirect = 1'b0;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_empty: got %b want 0", inst_valid); end
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h200) begin bad++; $display("FAIL same_cycle_addr: got req=%b addr=%h want req=1 addr=200", bus_req, bus_addr); end
        n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== 2 || inst_pc !== 32'h200) begin bad++; $display("FAIL same_cycle_first: got n=%0d pc=%h want n=2 pc=200", n, inst_pc); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus_gnt = 1'b1; rsp_en = 1'b0; inst_ready = 1'b0; rst = 1'b0;
        tick();
        tick();
        rsp_en = 1'b1;
        tick();
        rsp_en = 1'b0; bus_gnt = 1'b0;
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst !== KEY || bus_req !== 1'b1 || bus_addr !== 32'hC) begin bad++; $display("FAIL mid_pre: got v=%b inst=%h req=%b addr=%h want v=1 inst=%h req=1 addr=c", inst_valid, inst, bus_req, bus_addr, KEY); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_bus: got req=%b addr=%h want req=0 addr=0", bus_req, bus_addr); end
        total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("FAIL mid_rst_inst: got v=%b inst=%h pc=%h want all 0", inst_valid, inst, inst_pc); end
        tick();
        tick();
        pend.delete();
        issue_cnt = 0;
        bus_gnt = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin bad++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=0", bus_req, bus_addr); end
        bus_gnt = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_rvalid_pop();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
